// File: rtl/spi_rx_formatter.sv
// Formats received SPI words as ASCII binary display lines with a three-deep history
// and a header line showing a wrapping word count and a sticky overrun marker.
module spi_rx_formatter #(
  parameter int unsigned M = 15
) (
  input  logic           GCLK,
  input  logic           RST,
  input  logic [M-1:0]   RX_DATA,
  input  logic           RX_VALID,
  output logic [127:0]   str0,
  output logic [127:0]   str1,
  output logic [127:0]   str2,
  output logic [127:0]   str3,
  output logic           BUSY,
  output logic           DONE,
  output logic           DROP
);

  localparam logic [127:0] BLANK = {16{8'h20}};

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

  state_e       state_q;
  logic [15:0]  word_q;
  logic [3:0]   idx_q;
  logic [3:0]   pos_q;
  logic [127:0] line_q;
  logic [127:0] str0_q, str1_q, str2_q, str3_q;
  logic [7:0]   count_q;
  logic         done_q;
  logic         drop_q;
  logic         drop_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [127:0] header(input logic [7:0] cnt, input logic ovf);
    return {32'h52582023, hex_char(cnt[7:4]), hex_char(cnt[3:0]),
            (ovf ? 32'h204F5646 : 32'h20202020), 48'h202020202020};
  endfunction

  // Any valid strobe while a word is in flight (COMMIT included) is an overrun.
  always_comb begin
    drop_d = drop_q | ((state_q != IDLE) & RX_VALID);
  end

  always_ff @(posedge GCLK) begin
    if (RST) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      line_q  <= BLANK;
      str0_q  <= header(8'h00, 1'b0);
      str1_q  <= BLANK;
      str2_q  <= BLANK;
      str3_q  <= BLANK;
      count_q <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= drop_d;
      case (state_q)
        IDLE: begin
          if (RX_VALID) begin
            word_q  <= 16'(RX_DATA);
            idx_q   <= 4'(M - 1);
            pos_q   <= '0;
            state_q <= CONV;
          end
        end
        CONV: begin
          // char pos sits at bits [127-8*pos -: 8], i.e. lsb 8*(15-pos) = {~pos, 000}
          line_q[{~pos_q, 3'b000} +: 8] <= word_q[idx_q] ? 8'h31 : 8'h30;
          pos_q <= pos_q + 4'd1;
          idx_q <= idx_q - 4'd1;
          if (idx_q == 4'd0) state_q <= COMMIT;
        end
        COMMIT: begin
          str3_q  <= str2_q;
          str2_q  <= str1_q;
          str1_q  <= line_q;
          count_q <= count_q + 8'd1;
          str0_q  <= header(count_q + 8'd1, drop_d);
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign str0 = str0_q;
  assign str1 = str1_q;
  assign str2 = str2_q;
  assign str3 = str3_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign DROP = drop_q;

endmodule
